// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate prescaler, h/v position counters and
// registered sync, display-enable, pixel-coordinate and line/frame strobe outputs.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned H_W       = 10,
    parameter int unsigned V_W       = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           EN,
    output logic           VGA_HSYNC,
    output logic           VGA_VSYNC,
    output logic           DISPLAY_EN,
    output logic [H_W-1:0] HPIXEL,
    output logic [V_W-1:0] VPIXEL,
    output logic           PIX_EN,
    output logic           LINE_START,
    output logic           FRAME_START
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [H_W-1:0]   h_q;
    logic [V_W-1:0]   v_q;

    logic             tick;
    logic [H_W-1:0]   h_nxt;
    logic [V_W-1:0]   v_nxt;
    logic             de_nxt;
    logic             hs_act_nxt;
    logic             vs_act_nxt;

    // Pixel tick on the last enabled system clock of each prescaler period.
    always_comb begin
        tick = EN && (div_q == DIV_W'(CLK_DIV - 1));
    end

    // Position the raster moves to on the next tick, and its decode.
    always_comb begin
        h_nxt = h_q + H_W'(1);
        v_nxt = v_q;
        if (h_q == H_W'(H_TOTAL - 1)) begin
            h_nxt = '0;
            v_nxt = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + V_W'(1);
        end
        de_nxt     = (32'(h_nxt) < H_VISIBLE) && (32'(v_nxt) < V_VISIBLE);
        hs_act_nxt = (32'(h_nxt) >= H_SYNC_START) && (32'(h_nxt) < H_SYNC_END);
        vs_act_nxt = (32'(v_nxt) >= V_SYNC_START) && (32'(v_nxt) < V_SYNC_END);
    end

    // Counters and outputs advance together so outputs always describe (h_q, v_q).
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            h_q         <= H_W'(H_TOTAL - 1);
            v_q         <= V_W'(V_TOTAL - 1);
            VGA_HSYNC   <= ~HSYNC_POL;
            VGA_VSYNC   <= ~VSYNC_POL;
            DISPLAY_EN  <= 1'b0;
            HPIXEL      <= '0;
            VPIXEL      <= '0;
            PIX_EN      <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            PIX_EN      <= tick;
            LINE_START  <= tick && (h_nxt == '0);
            FRAME_START <= tick && (h_nxt == '0) && (v_nxt == '0);
            if (EN) begin
                div_q <= tick ? '0 : div_q + DIV_W'(1);
            end
            if (tick) begin
                h_q        <= h_nxt;
                v_q        <= v_nxt;
                DISPLAY_EN <= de_nxt;
                HPIXEL     <= de_nxt ? h_nxt : '0;
                VPIXEL     <= de_nxt ? v_nxt : '0;
                VGA_HSYNC  <= hs_act_nxt ? HSYNC_POL : ~HSYNC_POL;
                VGA_VSYNC  <= vs_act_nxt ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three configurations driven with shared
// directed and random EN/reset stimulus, checked against a frame-index model.
module tb_vga_timing_gen;

    typedef struct {
        int div;
        int hv, hfp, hsw, hbp;
        int vv, vfp, vsw, vbp;
        bit hpol, vpol;
    } cfg_t;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: small CLK_DIV=2 raster. Instance 2: tiny CLK_DIV=1, positive sync.
    logic       hs0, vs0, de0, pe0, ls0, fs0;
    logic [9:0] hp0, vp0;
    logic       hs1, vs1, de1, pe1, ls1, fs1;
    logic [4:0] hp1;
    logic [3:0] vp1;
    logic       hs2, vs2, de2, pe2, ls2, fs2;
    logic [2:0] hp2, vp2;

    vga_timing_gen u_dut0 (
        .clk(clk), .reset(rst), .EN(en),
        .VGA_HSYNC(hs0), .VGA_VSYNC(vs0), .DISPLAY_EN(de0),
        .HPIXEL(hp0), .VPIXEL(vp0),
        .PIX_EN(pe0), .LINE_START(ls0), .FRAME_START(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .H_W(5), .V_W(4)
    ) u_dut1 (
        .clk(clk), .reset(rst), .EN(en),
        .VGA_HSYNC(hs1), .VGA_VSYNC(vs1), .DISPLAY_EN(de1),
        .HPIXEL(hp1), .VPIXEL(vp1),
        .PIX_EN(pe1), .LINE_START(ls1), .FRAME_START(fs1)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .H_W(3), .V_W(3)
    ) u_dut2 (
        .clk(clk), .reset(rst), .EN(en),
        .VGA_HSYNC(hs2), .VGA_VSYNC(vs2), .DISPLAY_EN(de2),
        .HPIXEL(hp2), .VPIXEL(vp2),
        .PIX_EN(pe2), .LINE_START(ls2), .FRAME_START(fs2)
    );

    // Observed vector layout: {hsync, vsync, de, pix_en, line, frame, hpixel[9:0], vpixel[9:0]}
    logic [25:0] obs [N];
    assign obs[0] = {hs0, vs0, de0, pe0, ls0, fs0, hp0, vp0};
    assign obs[1] = {hs1, vs1, de1, pe1, ls1, fs1, 10'(hp1), 10'(vp1)};
    assign obs[2] = {hs2, vs2, de2, pe2, ls2, fs2, 10'(hp2), 10'(vp2)};

    cfg_t cfg [N];
    int   en_total [N];
    int   nticks   [N];
    bit   ticked   [N];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int first_fs  [N];
    int last_fs   [N];
    int fs_period [N];
    int last_ls0, ls_period0;

    // Model: every CLK_DIV-th enabled cycle since reset is a pixel tick; the n-th tick
    // shows raster index n-1 (mod frame size), scanned row-major from the first active pixel.
    function automatic void model_edge(int i, logic r, logic e);
        ticked[i] = 1'b0;
        if (r) begin
            en_total[i] = 0;
            nticks[i]   = 0;
        end else if (e) begin
            en_total[i] = en_total[i] + 1;
            if (en_total[i] % cfg[i].div == 0) ticked[i] = 1'b1;
            nticks[i] = en_total[i] / cfg[i].div;
        end
    endfunction

    function automatic logic [25:0] expect_out(int i);
        int ht, vt, idx, h, v;
        logic hs, vs, de, pe, ls, fs;
        logic [9:0] hp, vp;
        ht = cfg[i].hv + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp;
        vt = cfg[i].vv + cfg[i].vfp + cfg[i].vsw + cfg[i].vbp;
        hs = ~cfg[i].hpol; vs = ~cfg[i].vpol;
        de = 1'b0; pe = 1'b0; ls = 1'b0; fs = 1'b0;
        hp = '0; vp = '0;
        if (nticks[i] > 0) begin
            idx = (nticks[i] - 1) % (ht * vt);
            h = idx % ht;
            v = idx / ht;
            de = (h < cfg[i].hv) && (v < cfg[i].vv);
            if (de) begin
                hp = 10'(h);
                vp = 10'(v);
            end
            if (h >= cfg[i].hv + cfg[i].hfp && h < cfg[i].hv + cfg[i].hfp + cfg[i].hsw)
                hs = cfg[i].hpol;
            if (v >= cfg[i].vv + cfg[i].vfp && v < cfg[i].vv + cfg[i].vfp + cfg[i].vsw)
                vs = cfg[i].vpol;
            pe = ticked[i];
            ls = pe && (h == 0);
            fs = ls && (v == 0);
        end
        return {hs, vs, de, pe, ls, fs, hp, vp};
    endfunction

    task automatic clear_tracking();
        cyc = 0;
        last_ls0 = -1; ls_period0 = -1;
        for (int i = 0; i < N; i++) begin
            first_fs[i] = -1; last_fs[i] = -1; fs_period[i] = -1;
        end
    endtask

    // One clock: drive inputs at the falling edge, advance model, check at next falling edge.
    task automatic step(input logic r, input logic e);
        logic [25:0] exp_v;
        rst = r;
        en  = e;
        for (int i = 0; i < N; i++) model_edge(i, r, e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            exp_v = expect_out(i);
            tests++;
            assert (obs[i] === exp_v) else begin
                failed++;
                $error("FAIL out%0d cyc=%0d observed=%h expected=%h", i, cyc, obs[i], exp_v);
            end
            if (obs[i][20] === 1'b1) begin
                if (first_fs[i] < 0) first_fs[i] = cyc;
                if (last_fs[i] >= 0) fs_period[i] = cyc - last_fs[i];
                last_fs[i] = cyc;
            end
        end
        if (obs[0][21] === 1'b1) begin
            if (last_ls0 >= 0) ls_period0 = cyc - last_ls0;
            last_ls0 = cyc;
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_vec(input string tag, input logic [25:0] observed, input logic [25:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [25:0] snap;

    initial begin
        cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        cfg[1] = '{2, 16, 2, 3, 3, 6, 1, 2, 2, 1'b0, 1'b0};
        cfg[2] = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
        for (int i = 0; i < N; i++) begin
            en_total[i] = 0; nticks[i] = 0; ticked[i] = 1'b0;
        end
        @(negedge clk);

        // Reset held a few cycles, including with EN high.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_vec("reset_vec0", obs[0], 26'h3000000);

        // Free run from reset release.
        clear_tracking();
        for (int k = 0; k < 4000; k++) step(1'b0, 1'b1);
        check_int("first_frame_start0", first_fs[0], 2);
        check_int("first_frame_start2", first_fs[2], 1);
        check_int("line_period0", ls_period0, 1600);
        check_int("frame_period1", fs_period[1], 528);
        check_int("frame_period2", fs_period[2], 48);

        // Random EN gaps.
        for (int k = 0; k < 8000; k++) step(1'b0, ($urandom_range(0, 9) < 7));

        // Random EN with occasional reset pulses.
        for (int k = 0; k < 8000; k++)
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8));

        // EN low for 100 clocks: levels hold, strobes drop.
        step(1'b0, 1'b1);
        snap = obs[0];
        for (int k = 0; k < 100; k++) step(1'b0, 1'b0);
        check_vec("en_hold0", obs[0], {snap[25:23], 3'b000, snap[19:0]});

        // Single-clock reset mid-frame, then restart.
        for (int k = 0; k < 777; k++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_vec("midframe_reset0", obs[0], 26'h3000000);
        clear_tracking();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_int("restart_frame_start0", first_fs[0], 2);
        for (int k = 0; k < 600; k++) step(1'b0, 1'b1);
        check_int("restart_frame_period1", fs_period[1], 528);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
